// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch path: default widths used by the PC,
// the fetch unit and decode, plus the fetch sequencer state encoding.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer. Reads the PC, issues a memory read at that
// address, latches the returned word into the instruction register and offers
// it to decode over valid/ready. Drives the PC's increment/load controls so the
// PC advances once per completed fetch, or jumps on a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
);

  fetch_state_t state;
  fetch_state_t state_next;

  // A fetch completes only when memory answers and no redirect overrides it;
  // a redirect in the same cycle throws the returned word away.
  logic fetch_done;
  assign fetch_done = (state == FETCH) && mem_ready && !redirect;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: non-blocking assignment for every clocked register so all state
      // updates see the pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state logic; a redirect overrides every other transition.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // (otherwise a latch is inferred).
    state_next = state;
    if (redirect) begin
      state_next = enable ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE:    if (enable)    state_next = FETCH;
        FETCH:   if (mem_ready) state_next = HOLD;
        HOLD:    if (ir_ready)  state_next = enable ? FETCH : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode; PC strobes and the memory request are forced low in reset.
  always_comb begin
    mem_req  = !reset && (state == FETCH);
    pc_inc   = !reset && fetch_done;
    pc_load  = !reset && redirect;
    ir_valid = (state == HOLD);
  end

  // The fetch address is the live PC; it only moves after pc_inc/pc_load.
  assign mem_addr = pc_value;
  assign pc_next  = redirect_addr;

  // Instruction register: capture the word and its address on a completed fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the instruction register is small and observable, so it is
      // reset to zero rather than left undefined like a memory array would be.
      ir    <= '0;
      ir_pc <= '0;
    end else if (fetch_done) begin
      ir    <= mem_rdata;
      ir_pc <= pc_value;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. A small behavioural PC closes
// the loop through pc_inc/pc_load/pc_next; expectations are hand-computed.
module tb_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [ADDR_W-1:0]  pc_value;
  logic               pc_inc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_next;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_addr;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pc_value      (pc_value),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural program counter: load wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc_value <= '0;
    else if (pc_load) pc_value <= pc_next;
    else if (pc_inc)  pc_value <= pc_value + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    ir_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0099;
    #1;
    // Reset state, with a redirect asserted to prove strobes stay low.
    check("rst_ir",       ir,       0);
    check("rst_ir_pc",    ir_pc,    0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_req",  mem_req,  0);
    check("rst_pc_inc",   pc_inc,   0);
    check("rst_pc_load",  pc_load,  0);
    tick();
    redirect = 1'b0;
    tick();
    reset = 1'b0;

    // Zero-wait fetch at PC 0x0000.
    enable = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1234;
    #1;
    check("idle_mem_req", mem_req, 0);
    tick();
    check("zw_mem_req",  mem_req,  1);
    check("zw_mem_addr", mem_addr, 16'h0000);
    check("zw_pc_inc",   pc_inc,   1);
    tick();
    check("zw_ir",       ir,       16'h1234);
    check("zw_ir_pc",    ir_pc,    16'h0000);
    check("zw_ir_valid", ir_valid, 1);
    check("zw_inc_once", pc_inc,   0);
    check("zw_hold_req", mem_req,  0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("zw_next_addr", mem_addr, 16'h0001);

    // Redirect without data to move the PC to 0x0010.
    mem_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0010;
    #1;
    check("rd1_pc_load", pc_load, 1);
    check("rd1_pc_next", pc_next, 16'h0010);
    tick();
    redirect = 1'b0;

    // Wait states: three stalls, data on the fourth cycle.
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check("ws_mem_req",  mem_req,  1);
      check("ws_mem_addr", mem_addr, 16'h0010);
      check("ws_pc_inc",   pc_inc,   (i == 3) ? 1 : 0);
      tick();
    end
    mem_ready = 1'b0;
    check("ws_ir",    ir,    16'hBEEF);
    check("ws_ir_pc", ir_pc, 16'h0010);

    // Backpressure: decode stalls four cycles.
    for (int i = 0; i < 4; i++) begin
      check("bp_ir_valid", ir_valid, 1);
      check("bp_ir",       ir,       16'hBEEF);
      check("bp_mem_req",  mem_req,  0);
      tick();
    end
    ir_ready = 1'b1;
    #1;
    check("bp_accept_valid", ir_valid, 1);
    tick();
    ir_ready = 1'b0;
    check("bp_fetch_req",  mem_req,  1);
    check("bp_fetch_addr", mem_addr, 16'h0011);

    // Redirect coincident with returning data.
    mem_ready = 1'b1; mem_rdata = 16'hDEAD; redirect = 1'b1; redirect_addr = 16'h0040;
    #1;
    check("rdd_pc_load", pc_load, 1);
    check("rdd_pc_next", pc_next, 16'h0040);
    check("rdd_pc_inc",  pc_inc,  0);
    tick();
    redirect = 1'b0; mem_ready = 1'b0;
    check("rdd_ir",       ir,       16'hBEEF);
    check("rdd_ir_valid", ir_valid, 0);
    check("rdd_mem_req",  mem_req,  1);
    check("rdd_mem_addr", mem_addr, 16'h0040);

    // Enable drops mid-fetch; the fetch still completes.
    enable = 1'b0;
    #1;
    check("en_mem_req", mem_req, 1);
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    #1;
    check("en_pc_inc", pc_inc, 1);
    tick();
    mem_ready = 1'b0;
    check("en_ir_valid", ir_valid, 1);
    check("en_ir",       ir,       16'h5A5A);
    check("en_ir_pc",    ir_pc,    16'h0040);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("en_idle_valid", ir_valid, 0);
    check("en_idle_req",   mem_req,  0);
    tick();
    check("en_idle_req2", mem_req, 0);

    // Asynchronous reset while holding an instruction.
    enable = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ready = 1'b0;
    check("ar_pre_valid", ir_valid, 1);
    check("ar_pre_ir",    ir,       16'h7777);
    #2;
    reset = 1'b1;
    #1;
    check("ar_ir_valid", ir_valid, 0);
    check("ar_ir",       ir,       0);
    check("ar_ir_pc",    ir_pc,    0);
    check("ar_mem_req",  mem_req,  0);
    check("ar_pc_inc",   pc_inc,   0);
    check("ar_pc_load",  pc_load,  0);
    tick();
    check("ar_edge_req", mem_req, 0);
    check("ar_edge_inc", pc_inc,  0);
    enable = 1'b0;
    reset = 1'b0;
    tick();
    check("ar_wait_idle", mem_req, 0);
    enable = 1'b1;
    tick();
    check("ar_fetch_req",  mem_req,  1);
    check("ar_fetch_addr", mem_addr, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
